sys_feeder: RTL
===============

Name: sys_feeder

Overview:
- Activation-side transmitter for the systolic array rows.
- Accepts one SYS_ROW-wide activation vector per cycle over a valid/ready handshake.
- Drives each row's `in`/`en_in` pair with the diagonal skew the PE chain expects: row r is delayed r cycles relative to row 0.
- Tracks pass boundaries, drains the skew pipeline after the last vector, and signals completion to the MMU controller.

Parameters:
- SYS_ROW, 16, number of array rows fed (number of skew lanes); must be >= 1.
- DATA_WIDTH, 16, activation width; matches the array's DATA_WIDTH.
- CNT_WIDTH, 16, width of the vector counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort of the current pass.
- vec_valid  input  1  upstream vector valid.
- vec_ready  output  1  feeder can accept a vector this cycle.
- vec_data  input  DATA_WIDTH x SYS_ROW (unpacked [0:SYS_ROW-1])  activation vector; element r is for row r.
- vec_last  input  1  the accepted vector is the final one of the pass.
- row_in  output  DATA_WIDTH x SYS_ROW (unpacked [0:SYS_ROW-1])  per-row activation, drives row `in`.
- row_en  output  SYS_ROW  per-row enable, drives row `en_in[0]`.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse: the last vector's final element is on row SYS_ROW-1.
- vec_cnt  output  CNT_WIDTH  vectors accepted in the current or most recent pass.

Behaviour:
- Accept = vec_valid && vec_ready.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: accept && !vec_last -> STREAM; accept && vec_last -> DRAIN.
  - STREAM: accept && vec_last -> DRAIN; otherwise stay.
  - DRAIN: stay while drain_cnt != 0; drain_cnt == 0 -> IDLE.
- vec_ready = 1 in IDLE and STREAM; 0 in DRAIN.
- No backpressure from the array.
- Bubble handling: in STREAM with vec_valid = 0, a bubble (en = 0, data = 0) enters lane 0 and propagates through the skew like data.
- Skew pipeline: lane r is a chain of r+1 registers.
  - On accept at cycle t, element r appears on row_in[r] with row_en[r] = 1 at cycle t+1+r.
  - No accept at cycle t: lane entry loads en = 0, data = 0.
  - row_in[r] is 0 whenever row_en[r] is 0.
- drain_cnt: loaded with SYS_ROW-1 on the transition into DRAIN; decrements each DRAIN cycle.
- done = (state == DRAIN && drain_cnt == 0).
  - Last vector accepted at t gives done at t+SYS_ROW, coincident with row_en[SYS_ROW-1] = 1 for that vector.
  - IDLE at t+SYS_ROW+1.
  - SYS_ROW = 1: done at t+1.
- vec_cnt:
  - Accept from IDLE sets it to 1.
  - Each accept in STREAM increments it; it saturates at all-ones.
  - It holds its value after the pass until the next accept from IDLE.
- A new pass may be accepted in the cycle immediately after done. Its vectors never overlap the previous pass in any lane, because vec_ready was low through DRAIN.
- flush (same effect as rst except vec_cnt holds):
  - All skew registers clear to en = 0, data = 0.
  - state -> IDLE, drain_cnt -> 0, no done pulse.
  - An accept in the flush cycle is discarded.
  - flush wins over every other event in that cycle.
- rst: all registers clear.
  - Outputs after reset: row_in all 0, row_en 0, busy 0, done 0, vec_cnt 0, vec_ready 1 (IDLE).
  - Reset mid-pass discards in-flight data with no done pulse.

Test Plan:
- SYS_ROW = 4. Accept 3 back-to-back vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12} (last on the third) at cycles 0-2 ->
  - row_in[0] = 1,5,9 at cycles 1-3.
  - row_in[3] = 4,8,12 at cycles 4-6.
  - done at cycle 6; vec_cnt = 3; busy falls at cycle 7.
- Gap: vectors at cycles 0 and 2, vec_valid low at cycle 1 -> every lane shows en = 0, data = 0 exactly one cycle after its first element; second vector on row 2 at cycle 5.
- Single-vector pass with vec_last at cycle 0 ->
  - vec_ready low during cycles 1-4.
  - done at cycle 4.
  - vec_valid held high during DRAIN is not accepted until cycle 5.
- flush at cycle 2 of a 3-vector stream -> all row_en 0 from cycle 3; no done pulse; state IDLE; vec_cnt holds 2.
- rst asserted mid-DRAIN -> next cycle all outputs at reset values; vec_cnt = 0.
- SYS_ROW = 1, vec_cnt saturation: CNT_WIDTH = 2, 5 vectors -> vec_cnt stops at 3; done one cycle after the last accept.

Source files
------------

// File: rtl/sys_feeder.sv
// sys_feeder: skewed activation feeder for systolic array rows with pass tracking and drain
module sys_feeder #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  vec_valid,
  output logic                  vec_ready,
  input  logic [DATA_WIDTH-1:0] vec_data [0:SYS_ROW-1],
  input  logic                  vec_last,
  output logic [DATA_WIDTH-1:0] row_in [0:SYS_ROW-1],
  output logic [SYS_ROW-1:0]    row_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  vec_cnt
);
  localparam int DW = SYS_ROW > 1 ? $clog2(SYS_ROW) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t               state_q;
  logic [DW-1:0]        drain_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 take;
  assign vec_ready = state_q != DRAIN;
  assign take      = vec_valid && vec_ready && !flush;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DRAIN && drain_q == '0;
  assign vec_cnt   = cnt_q;
  always_comb cnt_d = state_q == IDLE ? CNT_WIDTH'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      if (take)
        cnt_q <= cnt_d;
      if (take && vec_last) begin
        state_q <= DRAIN;
        drain_q <= DW'(SYS_ROW - 1);
      end else if (take && state_q == IDLE) begin
        state_q <= STREAM;
      end else if (state_q == DRAIN) begin
        state_q <= drain_q == '0 ? IDLE : DRAIN;
        drain_q <= drain_q == '0 ? '0 : drain_q - 1'b1;
      end
    end
  end
  for (genvar r = 0; r < SYS_ROW; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] d_q [0:r];
    logic [r:0]            en_q;
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int i = 0; i <= r; i++) d_q[i] <= '0;
        en_q <= '0;
      end else begin
        d_q[0]  <= take ? vec_data[r] : '0;
        en_q[0] <= take;
        for (int i = 1; i <= r; i++) begin
          d_q[i]  <= d_q[i-1];
          en_q[i] <= en_q[i-1];
        end
      end
    end
    assign row_in[r] = d_q[r];
    assign row_en[r] = en_q[r];
  end
endmodule
